ascon_aead128_sched: RTL and testbench

//  Round-robin job scheduler that shares one ascon_aead128_core among NUM_REQ requesters.

---
 rtl/ascon_aead128_pkg.sv | 14 +
 rtl/ascon_aead128_sched_rr_arbiter.sv | 33 +++
 rtl/ascon_aead128_sched.sv | 140 ++++++++++++++
 tb/tb_ascon_aead128_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ascon_aead128_pkg.sv
// Shared types and widths for the ASCON-AEAD128 job scheduler.
package ascon_aead128_pkg;

  localparam int unsigned BLOCK_W = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    AD   = 3'd2,
    DB   = 3'd3,
    TAG  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/ascon_aead128_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IDX_W = $clog2(N);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned       c;
    logic [IDX_W-1:0]  ci;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      c = 32'(ptr) + i;
      if (c >= N) c = c - N;
      ci = IDX_W'(c);
      if (!any && req[ci]) begin
        any       = 1'b1;
        grant[ci] = 1'b1;
        idx       = ci;
      end
    end
  end

endmodule

// File: rtl/ascon_aead128_sched.sv
// Round-robin scheduler sharing one ascon_aead128_core among NUM_REQ requesters.
module ascon_aead128_sched
  import ascon_aead128_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*128-1:0]     req_key,
  input  logic [NUM_REQ*128-1:0]     req_nonce,
  input  logic [NUM_REQ*CNT_W-1:0]   req_n_ad,
  input  logic [NUM_REQ*CNT_W-1:0]   req_n_db,
  input  logic [NUM_REQ-1:0]         blk_valid,
  output logic [NUM_REQ-1:0]         blk_ready,
  input  logic [NUM_REQ*128-1:0]     blk_data,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic                       rsp_tag,
  output logic [127:0]               rsp_data,
  output logic                       busy,
  output logic                       core_start,
  output logic                       core_valid_ad,
  output logic                       core_valid_db_in,
  output logic [127:0]               core_ad,
  output logic [127:0]               core_db,
  output logic [127:0]               core_key,
  output logic [127:0]               core_nonce,
  input  logic                       core_ready,
  input  logic                       core_valid_db_out,
  input  logic                       core_valid_tag,
  input  logic [127:0]               core_dout
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  sched_state_e       state, state_nx;
  logic [IDX_W-1:0]   ptr, owner;
  logic [CNT_W-1:0]   ad_cnt, db_cnt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [CNT_W-1:0]   sel_n_ad, sel_n_db;
  logic [BLOCK_W-1:0] owner_blk;
  logic               owner_valid;
  logic               xfer;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sel_n_ad    = req_n_ad[CNT_W*arb_idx +: CNT_W];
  assign sel_n_db    = req_n_db[CNT_W*arb_idx +: CNT_W];
  assign owner_blk   = blk_data[BLOCK_W*owner +: BLOCK_W];
  assign owner_valid = blk_valid[owner];
  assign xfer        = owner_valid && core_ready;

  // Next state, core sequencing, block handshake and response routing.
  always_comb begin
    state_nx         = state;
    req_ready        = '0;
    blk_ready        = '0;
    rsp_valid        = '0;
    rsp_tag          = 1'b0;
    rsp_data         = '0;
    busy             = (state != IDLE);
    core_start       = 1'b0;
    core_valid_ad    = 1'b0;
    core_valid_db_in = 1'b0;
    core_ad          = (state != IDLE) ? owner_blk : '0;
    core_db          = (state != IDLE) ? owner_blk : '0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          state_nx  = LOAD;
        end
      end
      LOAD: begin
        core_start = 1'b1;
        state_nx   = (ad_cnt != '0) ? AD : DB;
      end
      AD: begin
        core_valid_ad    = owner_valid;
        blk_ready[owner] = core_ready;
        if (xfer && ad_cnt == CNT_W'(1)) state_nx = DB;
      end
      DB: begin
        core_valid_db_in = owner_valid;
        core_start       = (db_cnt != CNT_W'(1));
        blk_ready[owner] = core_ready;
        if (xfer && db_cnt == CNT_W'(1)) state_nx = TAG;
      end
      default: ;
    endcase
    if (state != IDLE) begin
      if (core_valid_tag) begin
        rsp_valid[owner] = 1'b1;
        rsp_tag          = 1'b1;
        rsp_data         = core_dout;
        state_nx         = IDLE;
      end else if (core_valid_db_out) begin
        rsp_valid[owner] = 1'b1;
        rsp_data         = core_dout;
      end
    end
  end

  // State, job descriptor latch, block counters and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      ad_cnt     <= '0;
      db_cnt     <= '0;
      core_key   <= '0;
      core_nonce <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && arb_any) begin
        owner      <= arb_idx;
        core_key   <= req_key[BLOCK_W*arb_idx +: BLOCK_W];
        core_nonce <= req_nonce[BLOCK_W*arb_idx +: BLOCK_W];
        ad_cnt     <= sel_n_ad;
        db_cnt     <= (sel_n_db == '0) ? CNT_W'(1) : sel_n_db;
      end
      if (state == AD && xfer) ad_cnt <= ad_cnt - CNT_W'(1);
      if (state == DB && xfer) db_cnt <= db_cnt - CNT_W'(1);
      if (state != IDLE && core_valid_tag)
        ptr <= (32'(owner) == NUM_REQ - 1) ? '0 : owner + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_ascon_aead128_sched.sv
// Directed self-checking bench for ascon_aead128_sched; the core is emulated by the bench.
module tb_ascon_aead128_sched;

  localparam int unsigned NR = 2;
  localparam int unsigned CW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*128-1:0] req_key, req_nonce;
  logic [NR*CW-1:0]  req_n_ad, req_n_db;
  logic [NR-1:0]     blk_valid, blk_ready;
  logic [NR*128-1:0] blk_data;
  logic [NR-1:0]     rsp_valid;
  logic              rsp_tag;
  logic [127:0]      rsp_data;
  logic              busy, core_start, core_valid_ad, core_valid_db_in;
  logic [127:0]      core_ad, core_db, core_key, core_nonce;
  logic              core_ready, core_valid_db_out, core_valid_tag;
  logic [127:0]      core_dout;

  int checks = 0;
  int failures = 0;
  int job_no = 0;
  logic [127:0] exp_key [NR];
  logic [127:0] exp_nonce [NR];

  always #5 clk = ~clk;

  ascon_aead128_sched #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_nonce(req_nonce),
    .req_n_ad(req_n_ad), .req_n_db(req_n_db),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .busy(busy), .core_start(core_start), .core_valid_ad(core_valid_ad),
    .core_valid_db_in(core_valid_db_in), .core_ad(core_ad), .core_db(core_db),
    .core_key(core_key), .core_nonce(core_nonce), .core_ready(core_ready),
    .core_valid_db_out(core_valid_db_out), .core_valid_tag(core_valid_tag),
    .core_dout(core_dout)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int ch, input int nad, input int ndb);
    job_no++;
    exp_key[ch]   = {32'hBEEF0000 + 32'(job_no), 96'h0123_4567_89AB_CDEF_0011_2233};
    exp_nonce[ch] = {96'h4455_6677_8899_AABB_CCDD_EEFF, 32'hF00D0000 + 32'(job_no)};
    req_key[ch*128 +: 128]   = exp_key[ch];
    req_nonce[ch*128 +: 128] = exp_nonce[ch];
    req_n_ad[ch*CW +: CW]    = CW'(nad);
    req_n_db[ch*CW +: CW]    = CW'(ndb);
    req_valid[ch]            = 1'b1;
  endtask

  // Runs one whole job; entered in IDLE with the request already presented.
  task automatic do_job(input int ch, input int nad, input int ndb, input bit keep, input bit stall);
    logic [NR-1:0] oh;
    logic [127:0]  d, r;
    int ad_left, db_left, guard;
    bit v, rd;
    oh = NR'(1) << ch;
    ad_left = nad;
    db_left = (ndb == 0) ? 1 : ndb;
    #1;
    chk("grant_ready", 128'(req_ready), 128'(oh));
    chk("grant_idle_busy", 128'(busy), 128'(0));
    tick();
    if (!keep) req_valid = '0;
    #1;
    chk("load_start", 128'(core_start), 128'(1));
    chk("load_busy", 128'(busy), 128'(1));
    chk("load_key", core_key, exp_key[ch]);
    chk("load_nonce", core_nonce, exp_nonce[ch]);
    tick();
    guard = 0;
    while ((ad_left + db_left) > 0 && guard < 300) begin
      v  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rd = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      d  = {32'(ch), 32'(job_no), 32'(ad_left), 32'(db_left)};
      r  = {$urandom, $urandom, $urandom, $urandom};
      blk_data = {NR*128{1'b1}};
      blk_data[ch*128 +: 128] = d;
      blk_valid = ~oh | (v ? oh : '0);
      core_ready = rd;
      core_valid_db_out = (ad_left == 0);
      core_dout = r;
      #1;
      chk("blk_ready_owner", 128'(blk_ready), 128'(rd ? oh : '0));
      chk("core_ad_mux", core_ad, d);
      chk("no_grant_in_job", 128'(req_ready), 128'(0));
      if (ad_left > 0) begin
        chk("ad_valid", 128'(core_valid_ad), 128'(v));
        chk("ad_no_db", 128'(core_valid_db_in), 128'(0));
        chk("ad_rsp_idle", 128'(rsp_valid), 128'(0));
      end else begin
        chk("db_valid", 128'(core_valid_db_in), 128'(v));
        chk("db_start", 128'(core_start), 128'(db_left != 1));
        chk("db_rsp_valid", 128'(rsp_valid), 128'(oh));
        chk("db_rsp_tag", 128'(rsp_tag), 128'(0));
        chk("db_rsp_data", rsp_data, r);
      end
      if (v && rd) begin
        if (ad_left > 0) ad_left--;
        else db_left--;
      end
      guard++;
      tick();
    end
    chk("xfer_budget", 128'(guard < 300), 128'(1));
    blk_valid = '1;
    core_ready = 1'b1;
    core_valid_db_out = 1'b0;
    #1;
    chk("tag_no_db", 128'(core_valid_db_in), 128'(0));
    chk("tag_no_start", 128'(core_start), 128'(0));
    chk("tag_no_ready", 128'(blk_ready), 128'(0));
    chk("tag_busy", 128'(busy), 128'(1));
    core_valid_tag = 1'b1;
    core_dout = {32'hCAFE0000 + 32'(job_no), 96'h5A5A};
    #1;
    chk("tag_rsp_valid", 128'(rsp_valid), 128'(oh));
    chk("tag_rsp_tag", 128'(rsp_tag), 128'(1));
    chk("tag_rsp_data", rsp_data, {32'hCAFE0000 + 32'(job_no), 96'h5A5A});
    tick();
    core_valid_tag = 1'b0;
    blk_valid = '0;
    #1;
    chk("end_busy", 128'(busy), 128'(0));
    chk("end_rsp", 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_key = '0; req_nonce = '0; req_n_ad = '0; req_n_db = '0;
    blk_valid = '0; blk_data = '0;
    core_ready = 1'b0; core_valid_db_out = 1'b0; core_valid_tag = 1'b0; core_dout = '0;
    tick(); tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_start", 128'(core_start), 128'(0));
    chk("rst_key", core_key, 128'(0));
    rst = 1'b0;
    tick();

    // Basic job on channel 0 with channel 1 driving stray blocks.
    set_job(0, 1, 2);
    do_job(0, 1, 2, 1'b0, 1'b0);

    // Reset in the middle of the data phase.
    set_job(0, 0, 3);
    #1;
    chk("r5_grant", 128'(req_ready), 128'(1));
    tick();
    req_valid = '0;
    tick();
    blk_valid = '1; core_ready = 1'b1; core_valid_db_out = 1'b1; core_dout = 128'h77;
    #1;
    chk("r5_db_valid", 128'(core_valid_db_in), 128'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("r5_busy", 128'(busy), 128'(0));
    chk("r5_start", 128'(core_start), 128'(0));
    chk("r5_db_in", 128'(core_valid_db_in), 128'(0));
    chk("r5_ad", 128'(core_valid_ad), 128'(0));
    chk("r5_rsp", 128'(rsp_valid), 128'(0));
    chk("r5_blk_ready", 128'(blk_ready), 128'(0));
    chk("r5_key", core_key, 128'(0));
    blk_valid = '0; core_valid_db_out = 1'b0;
    tick();

    // Both channels requesting continuously: grants alternate 0,1,0,1.
    set_job(0, 1, 1);
    set_job(1, 2, 1);
    do_job(0, 1, 1, 1'b1, 1'b0);
    set_job(0, 0, 2);
    do_job(1, 2, 1, 1'b1, 1'b0);
    set_job(1, 1, 0);
    do_job(0, 0, 2, 1'b1, 1'b0);
    do_job(1, 1, 0, 1'b0, 1'b0);

    // No AD, zero data count clamped to a single last block.
    set_job(0, 0, 0);
    do_job(0, 0, 0, 1'b0, 1'b0);

    // Random valid/ready stalls on channel 1.
    set_job(1, 3, 4);
    do_job(1, 3, 4, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
